// File: rtl/piso_serializer_if.sv
// Parallel-load / serial-out handshake bundle for piso_serializer.
// The master owns the load side; the slave (the serializer) drives the serial side.
interface piso_serializer_if #(
    parameter int N = 4
);
    logic [N-1:0] load_data;
    logic         load_valid;
    logic         load_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         last;
    logic         busy;

    modport master (
        output load_data, load_valid,
        input  load_ready, ser_out, ser_valid, last, busy
    );

    modport slave (
        input  load_data, load_valid,
        output load_ready, ser_out, ser_valid, last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: accepts an N-bit word and emits it one bit per clock.
//   state | meaning
//   IDLE  | no word in flight; serial outputs held at 0, ready for a word
//   SHIFT | shifting a word out; a new word may be taken on its last bit
module piso_serializer #(
    parameter int N         = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serializer_if.slave   bus
);
    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic            last_w;
    logic            accept_w;
    logic            out_bit_w;
    logic [N-1:0]    shifted_w;

    // Serial-side outputs depend only on registered state.
    assign last_w    = (state_q == SHIFT) && (cnt_q == CW'(N - 1));
    assign out_bit_w = LSB_FIRST ? shreg_q[0] : shreg_q[N-1];
    assign shifted_w = LSB_FIRST ? {1'b0, shreg_q[N-1:1]} : {shreg_q[N-2:0], 1'b0};

    assign bus.load_ready = (state_q == IDLE) || last_w;
    assign bus.ser_valid  = (state_q == SHIFT);
    assign bus.busy       = (state_q == SHIFT);
    assign bus.last       = last_w;
    assign bus.ser_out    = (state_q == SHIFT) ? out_bit_w : 1'b0;

    assign accept_w = bus.load_valid && bus.load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept_w) begin
            // A load on the last bit reloads in place, so words run back to back.
            state_d = SHIFT;
            shreg_d = bus.load_data;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            shreg_d = shifted_w;
            if (last_w) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one LSB-first and one MSB-first instance, N=4.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_piso_serializer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    piso_serializer_if #(.N(4)) if_a ();
    piso_serializer_if #(.N(4)) if_b ();

    piso_serializer #(.N(4), .LSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    piso_serializer #(.N(4), .LSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_bit(input string tag, input logic exp_bit, input logic exp_last);
        check({tag, ".valid"}, 32'(if_a.ser_valid), 32'd1);
        check({tag, ".out"},   32'(if_a.ser_out),   32'(exp_bit));
        check({tag, ".last"},  32'(if_a.last),      32'(exp_last));
        check({tag, ".busy"},  32'(if_a.busy),      32'd1);
    endtask

    task automatic check_a_idle(input string tag);
        check({tag, ".valid"}, 32'(if_a.ser_valid),  32'd0);
        check({tag, ".out"},   32'(if_a.ser_out),    32'd0);
        check({tag, ".last"},  32'(if_a.last),       32'd0);
        check({tag, ".busy"},  32'(if_a.busy),       32'd0);
        check({tag, ".ready"}, 32'(if_a.load_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] exp_single;
        logic [7:0] exp_b2b;
        logic [6:0] exp_busy;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        if_a.load_valid = 1'b1;
        if_a.load_data  = 4'hF;
        if_b.load_valid = 1'b0;
        if_b.load_data  = 4'h0;

        // Reset held two edges with a pending handshake that must be ignored.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst.valid", 32'(if_a.ser_valid), 32'd0);
            check("rst.out",   32'(if_a.ser_out),   32'd0);
            check("rst.busy",  32'(if_a.busy),      32'd0);
        end
        rst_n = 1'b1;
        if_a.load_valid = 1'b0;
        check("rst.ready_after", 32'(if_a.load_ready), 32'd1);
        tick();
        check_a_idle("rst.no_accept");
        check("rst.b_idle", 32'(if_b.ser_valid), 32'd0);

        // Single word 1011, LSB first: 1,1,0,1.
        exp_single = 4'b1011;
        if_a.load_data  = 4'b1011;
        if_a.load_valid = 1'b1;
        tick();
        if_a.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_a_bit("single", exp_single[i], i == 3);
            if (i < 3) tick();
        end
        tick();
        check_a_idle("single.end");

        // Back-to-back: A then 5 -> 0,1,0,1,1,0,1,0 with no gap.
        exp_b2b = 8'b0101_1010;
        if_a.load_data  = 4'hA;
        if_a.load_valid = 1'b1;
        tick();
        if_a.load_data = 4'h5;
        for (int j = 0; j < 8; j++) begin
            check_a_bit("b2b", exp_b2b[j], (j == 3) || (j == 7));
            if (j == 1) check("b2b.ready_mid", 32'(if_a.load_ready), 32'd0);
            if (j == 3) check("b2b.ready_last", 32'(if_a.load_ready), 32'd1);
            tick();
            if (j == 3) if_a.load_valid = 1'b0;
        end
        check_a_idle("b2b.end");

        // Busy rejection: F offered during bit 1 of word 0, taken only at its last bit.
        exp_busy = 7'b1111_000;
        if_a.load_data  = 4'h0;
        if_a.load_valid = 1'b1;
        tick();
        if_a.load_valid = 1'b0;
        check_a_bit("busy.bit0", 1'b0, 1'b0);
        tick();
        if_a.load_data  = 4'hF;
        if_a.load_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            check_a_bit("busy", exp_busy[k], (k == 2) || (k == 6));
            if (k < 2) check("busy.ready", 32'(if_a.load_ready), 32'd0);
            tick();
            if (k == 2) if_a.load_valid = 1'b0;
        end
        check_a_idle("busy.end");

        // Mid-word reset during bit 2 of 1111, then 0110 -> 0,1,1,0.
        if_a.load_data  = 4'b1111;
        if_a.load_valid = 1'b1;
        tick();
        if_a.load_valid = 1'b0;
        tick();
        tick();
        check_a_bit("mrst.bit2", 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_a_idle("mrst.abort");
        exp_single = 4'b0110;
        if_a.load_data  = 4'b0110;
        if_a.load_valid = 1'b1;
        tick();
        if_a.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_a_bit("mrst.word", exp_single[i], i == 3);
            if (i < 3) tick();
        end
        tick();
        check_a_idle("mrst.end");

        // MSB first on the second instance: 1000 -> 1,0,0,0.
        exp_single = 4'b0001;
        if_b.load_data  = 4'b1000;
        if_b.load_valid = 1'b1;
        tick();
        if_b.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("msb.valid", 32'(if_b.ser_valid), 32'd1);
            check("msb.out",   32'(if_b.ser_out),   32'(exp_single[i]));
            check("msb.last",  32'(if_b.last),      32'(i == 3));
            if (i < 3) tick();
        end
        tick();
        check("msb.end_valid", 32'(if_b.ser_valid), 32'd0);
        check("msb.end_busy",  32'(if_b.busy),      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
